// File: rtl/accel_host_seq.sv
// Host sequencer for the bit-reverse accelerator: TX buffer -> LOAD/WAIT/DRAIN/FLUSH -> RX buffer.
// Job length N completes in 2N+3 cycles when done is immediate; an optional cycle counter is built under `ACC_SEQ_PERF_EN.

module accel_host_seq_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_vld_i,
  input  logic [W-1:0]           in_dat_i,
  output logic                   out_vld_o,
  output logic [W-1:0]           out_dat_o,
  input  logic                   out_rdy_i,
  output logic [$clog2(DEPTH):0] cnt_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wp_q, wp_d, rp_q, rp_d;
  logic         full, push, pop;

  assign cnt_o     = wp_q - rp_q;
  assign full      = (cnt_o == (AW+1)'(DEPTH));
  assign out_vld_o = (cnt_o != '0);
  assign out_dat_o = out_vld_o ? mem_q[rp_q[AW-1:0]] : '0;
  assign pop       = out_vld_o && out_rdy_i;
  // On a full buffer a same-cycle pop frees the slot this push lands in.
  assign push      = in_vld_i && (!full || pop);
  assign wp_d      = push ? wp_q + 1'b1 : wp_q;
  assign rp_d      = pop  ? rp_q + 1'b1 : rp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= in_dat_i;
  end
endmodule

module accel_host_seq #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic                     wr_ready_o,
  input  logic                     go_i,
  input  logic [$clog2(DEPTH):0]   len_i,
  output logic                     rd_valid_o,
  output logic [DATA_W-1:0]        rd_data_o,
  input  logic                     rd_ready_i,
  output logic                     busy_o,
  output logic                     err_o,
  output logic [DATA_W-1:0]        acc_din_o,
  output logic                     acc_start_o,
  input  logic                     acc_done_i,
  input  logic [DATA_W-1:0]        acc_dout_i,
  output logic                     acc_read_o,
  output logic [31:0]              perf_cycles_o
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_DRAIN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     len_q, len_d, cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              start_q, start_d, err_q, err_d, pend_q;
  logic              tx_pop, tx_vld, acc_rd, go_ok;
  logic [DATA_W-1:0] tx_head;
  logic [LW-1:0]     tx_cnt, rx_cnt;
  logic [LW:0]       rx_used;

  accel_host_seq_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst_n(rst_n), .in_vld_i(wr_valid_i), .in_dat_i(wr_data_i),
    .out_vld_o(tx_vld), .out_dat_o(tx_head), .out_rdy_i(tx_pop), .cnt_o(tx_cnt)
  );

  // Each strobe's result arrives one cycle later and is always captured.
  accel_host_seq_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst_n(rst_n), .in_vld_i(pend_q), .in_dat_i(acc_dout_i),
    .out_vld_o(rd_valid_o), .out_dat_o(rd_data_o), .out_rdy_i(rd_ready_i), .cnt_o(rx_cnt)
  );

  assign wr_ready_o  = rst_n && ((tx_cnt != LW'(DEPTH)) || tx_pop);
  assign busy_o      = (state_q != S_IDLE);
  assign err_o       = err_q;
  assign acc_din_o   = din_q;
  assign acc_start_o = start_q;
  assign acc_read_o  = acc_rd;
  assign go_ok       = tx_vld && (len_i != '0) && (len_i <= LW'(DEPTH)) && (tx_cnt >= len_i);
  assign rx_used     = {1'b0, rx_cnt} + {{LW{1'b0}}, pend_q};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    din_d   = din_q;
    start_d = 1'b0;
    err_d   = err_q;
    tx_pop  = 1'b0;
    acc_rd  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_i) begin
          if (go_ok) begin
            // Word 0 is popped on acceptance so it appears with start in the next cycle.
            len_d   = len_i;
            err_d   = 1'b0;
            tx_pop  = 1'b1;
            din_d   = tx_head;
            start_d = 1'b1;
            cnt_d   = LW'(1);
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (cnt_q < len_q) begin
          tx_pop = 1'b1;
          din_d  = tx_head;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          din_d   = '0;
          to_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (acc_done_i) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else if (to_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (rx_used < (LW+1)'(DEPTH)) begin
          acc_rd = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == len_q - LW'(1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      din_q   <= din_d;
      start_q <= start_d;
      err_q   <= err_d;
      pend_q  <= acc_rd;
    end
  end

`ifdef ACC_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        go_acc;

  assign go_acc = (state_q == S_IDLE) && go_i && go_ok;

  // The accepting cycle counts as the job's first cycle.
  always_comb begin
    perf_d = perf_q;
    if (go_acc) perf_d = 32'd1;
    else if (busy_o && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif
endmodule

// File: tb/tb_accel_host_seq.sv
// Directed bench for accel_host_seq with a negedge-driven bit-reverse accelerator model.

module tb_accel_host_seq;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int TIMEOUT = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_ready_o;
  logic          go_i = 1'b0;
  logic [4:0]    len_i = '0;
  logic          rd_valid_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_ready_i = 1'b0;
  logic          busy_o, err_o;
  logic [DW-1:0] acc_din_o;
  logic          acc_start_o;
  logic          acc_done_i = 1'b0;
  logic [DW-1:0] acc_dout_i = '0;
  logic          acc_read_o;
  logic [31:0]   perf_cycles_o;

  int n_assert = 0;
  int n_fail = 0;

  accel_host_seq #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .go_i(go_i), .len_i(len_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .err_o(err_o),
    .acc_din_o(acc_din_o), .acc_start_o(acc_start_o), .acc_done_i(acc_done_i),
    .acc_dout_i(acc_dout_i), .acc_read_o(acc_read_o), .perf_cycles_o(perf_cycles_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bitrev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // Accelerator model: collects len words from start, raises done after m_delay cycles,
  // returns bit-reversed results one cycle after each read strobe.
  int          m_len = 1, m_delay = 0, m_idx = 0, m_rd = 0, m_cd = 0;
  bit          m_coll = 0, m_prev_rd = 0, done_en = 1;
  logic [31:0] m_words [16];
  int          start_cnt = 0, read_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_coll = 0; m_prev_rd = 0; m_cd = 0; acc_done_i = 1'b0; acc_dout_i = '0;
    end else begin
      if (m_prev_rd) begin
        acc_dout_i = bitrev(m_words[m_rd % 16]);
        m_rd++;
      end
      m_prev_rd = acc_read_o;
      if (acc_read_o) read_cnt++;
      if (acc_start_o) begin
        start_cnt++; m_coll = 1; m_idx = 0; m_rd = 0; acc_done_i = 1'b0;
      end
      if (m_coll) begin
        m_words[m_idx % 16] = acc_din_o;
        m_idx++;
        if (m_idx == m_len) begin
          m_coll = 0;
          if (m_delay == 0) acc_done_i = done_en;
          else m_cd = m_delay;
        end
      end else if (m_cd > 0) begin
        m_cd--;
        if (m_cd == 0) acc_done_i = done_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic go(input int len);
    go_i  = 1'b1;
    len_i = 5'(len);
    tick();
    go_i  = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_vld"}, {31'b0, rd_valid_o}, 32'd1);
    chk(tag, rd_data_o, exp);
    rd_ready_i = 1'b1;
    tick();
    rd_ready_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    for (int i = 0; i < bound && busy_o; i++) tick();
    chk({tag, "_idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  int s0, r0;
  logic [31:0] perf_exp;

  initial begin
    tick(); tick();
    // Reset state
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    chk("rst_wr_ready", {31'b0, wr_ready_o}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid_o}, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_start", {31'b0, acc_start_o}, 0);
    chk("rst_perf", perf_cycles_o, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_wr_ready", {31'b0, wr_ready_o}, 1);

    // Basic 4-word job, done 5 cycles after the last word
    s0 = start_cnt; r0 = read_cnt;
    m_len = 4; m_delay = 5;
    push(32'h0000_0001); push(32'h0000_0002); push(32'h0000_0003); push(32'h8000_0000);
    go(4);
    chk("t1_busy", {31'b0, busy_o}, 1);
    wait_idle("t1", 200);
    chk("t1_err", {31'b0, err_o}, 0);
    chk("t1_starts", 32'(start_cnt - s0), 1);
    chk("t1_reads", 32'(read_cnt - r0), 4);
    pop_chk("t1_r0", 32'h8000_0000);
    pop_chk("t1_r1", 32'h4000_0000);
    pop_chk("t1_r2", 32'hC000_0000);
    pop_chk("t1_r3", 32'h0000_0001);
    chk("t1_rx_empty", {31'b0, rd_valid_o}, 0);
    chk("t1_rx_data0", rd_data_o, 0);

    // go rejected for lack of TX words, then accepted
    s0 = start_cnt;
    m_len = 3; m_delay = 2;
    push(32'h0000_000F); push(32'h1234_5678);
    go(3);
    chk("t2_rej_err", {31'b0, err_o}, 1);
    chk("t2_rej_busy", {31'b0, busy_o}, 0);
    tick();
    chk("t2_rej_start", 32'(start_cnt - s0), 0);
    push(32'hFFFF_0000);
    go(3);
    chk("t2_acc_err", {31'b0, err_o}, 0);
    chk("t2_acc_busy", {31'b0, busy_o}, 1);
    go(0);
    tick();
    chk("t2_busy_go_ignored", {31'b0, err_o}, 0);
    wait_idle("t2", 200);
    pop_chk("t2_r0", 32'hF000_0000);
    pop_chk("t2_r1", 32'h1E6A_2C48);
    pop_chk("t2_r2", 32'h0000_FFFF);

    // Full-depth job with host never popping
    r0 = read_cnt;
    m_len = 16; m_delay = 1;
    for (int i = 0; i < 16; i++) push(32'h1 << i);
    chk("t3_tx_full", {31'b0, wr_ready_o}, 0);
    go_i = 1'b1; len_i = 5'd16;
    #1;
    chk("t3_full_pop_ready", {31'b0, wr_ready_o}, 1);
    tick();
    go_i = 1'b0;
    wait_idle("t3", 300);
    chk("t3_err", {31'b0, err_o}, 0);
    chk("t3_reads", 32'(read_cnt - r0), 16);
    for (int i = 0; i < 16; i++) pop_chk("t3_r", 32'h8000_0000 >> i);
    chk("t3_rx_empty", {31'b0, rd_valid_o}, 0);

    // WAIT timeout: done never returned
    r0 = read_cnt;
    done_en = 0; m_len = 2;
    push(32'hAAAA_0001); push(32'hAAAA_0002);
    go(2);
    for (int i = 0; i < 41; i++) tick();
    chk("t4_err_before", {31'b0, err_o}, 0);
    chk("t4_busy_before", {31'b0, busy_o}, 1);
    tick();
    chk("t4_err_at", {31'b0, err_o}, 1);
    chk("t4_busy_at", {31'b0, busy_o}, 0);
    chk("t4_reads", 32'(read_cnt - r0), 0);
    done_en = 1;

    // Reset in the middle of LOAD
    m_len = 8; m_delay = 0;
    for (int i = 0; i < 8; i++) push(32'h5500_0000 + 32'(i));
    go(8);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy_o}, 0);
    chk("t5_err", {31'b0, err_o}, 0);
    chk("t5_din", acc_din_o, 0);
    chk("t5_start", {31'b0, acc_start_o}, 0);
    chk("t5_read", {31'b0, acc_read_o}, 0);
    chk("t5_wr_ready", {31'b0, wr_ready_o}, 0);
    chk("t5_rd_valid", {31'b0, rd_valid_o}, 0);
    chk("t5_perf", perf_cycles_o, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    go(1);
    chk("t5_tx_empty_rej", {31'b0, err_o}, 1);
    m_len = 2;
    push(32'h0000_00F0); push(32'h0000_0100);
    go(2);
    chk("t5_err_cleared", {31'b0, err_o}, 0);
    wait_idle("t5", 200);
    pop_chk("t5_r0", 32'h0F00_0000);
    pop_chk("t5_r1", 32'h0080_0000);

    // Cycle-exact len=1 job with immediate done
    m_len = 1; m_delay = 0;
    push(32'h0000_0005);
    go(1);
    chk("t6_c1_start", {31'b0, acc_start_o}, 1);
    chk("t6_c1_din", acc_din_o, 32'h0000_0005);
    tick();
    chk("t6_c2_start", {31'b0, acc_start_o}, 0);
    chk("t6_c2_din", acc_din_o, 0);
    tick();
    chk("t6_c3_read", {31'b0, acc_read_o}, 1);
    tick();
    chk("t6_c4_busy", {31'b0, busy_o}, 1);
    chk("t6_c4_read", {31'b0, acc_read_o}, 0);
    tick();
    chk("t6_c5_busy", {31'b0, busy_o}, 0);
`ifdef ACC_SEQ_PERF_EN
    perf_exp = 32'd5;
`else
    perf_exp = 32'd0;
`endif
    chk("t6_perf", perf_cycles_o, perf_exp);
    tick();
    chk("t6_perf_hold", perf_cycles_o, perf_exp);
    pop_chk("t6_r0", 32'hA000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/accel_host_seq.md
Name: accel_host_seq

Overview:
- Host-side sequencer for the bit-reverse accelerator subsystem. It drives the subsystem's din/start/read inputs and consumes its dout/done outputs.
- The host pushes job words into a TX buffer, then issues go with a length. The block bursts the words into the accelerator, waits for done, and drains the results into an RX buffer.
- The host pops results from the RX buffer with a valid/ready handshake.
- It sits between the processor-side register/bus logic and the accelerator wrapper.

Parameters:
- DATA_W, 32, data word width.
- DEPTH, 16, TX and RX buffer depth in words; must be a power of 2, 2 or greater.
- TIMEOUT, 1024, maximum cycles in WAIT before an error abort.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid_i  in  1  host TX push valid.
- wr_data_i  in  DATA_W  host TX push data.
- wr_ready_o  out  1  TX buffer not full.
- go_i  in  1  job start request; single-cycle pulse.
- len_i  in  $clog2(DEPTH)+1  job word count, sampled when go_i is accepted.
- rd_valid_o  out  1  RX buffer not empty.
- rd_data_o  out  DATA_W  RX buffer head word.
- rd_ready_i  in  1  host RX pop.
- busy_o  out  1  high when the FSM is not in IDLE.
- err_o  out  1  sticky error flag.
- acc_din_o  out  DATA_W  word to the accelerator.
- acc_start_o  out  1  accelerator start; high for exactly the first load cycle.
- acc_done_i  in  1  accelerator done level.
- acc_dout_i  in  DATA_W  accelerator result data.
- acc_read_o  out  1  result read strobe.
- perf_cycles_o  out  32  job cycle count (see Optional Feature).

Behaviour:
- Reset values (async on rst_n low, released synchronously): all outputs 0, both buffers empty, FSM in IDLE, all counters 0. Reset mid-job aborts immediately with no further acc_* activity. rd_data_o reads as 0 while the RX buffer is empty.
- Buffers are FWFT FIFOs with DEPTH entries. Pointers are $clog2(DEPTH)+1 bits, with the MSB used for wrap.
  - A push happens when valid && ready; a pop happens when valid && ready.
  - Simultaneous push and pop on a full or empty buffer is legal: on full, the pop frees the slot the push uses in the same cycle; on empty, the push is not visible until the next cycle.
  - The count stays within 0..DEPTH.
  - Host TX pushes are allowed in every state, so the next job can be preloaded.
- go acceptance: go_i is accepted only if busy_o=0, 1<=len_i<=DEPTH, and the TX count is at least len_i.
  - Accepted: latch len into a job length register, clear err_o, and go to LOAD.
  - Rejected: set err_o and stay in IDLE.
  - go_i while busy_o=1 is ignored; err_o is unchanged.
- LOAD: pop one TX word per cycle onto acc_din_o (registered) for len consecutive cycles, with no gaps.
  - acc_start_o=1 only in the cycle that carries word 0.
  - After word len-1, go to WAIT and drive acc_din_o to 0.
- WAIT: wait for acc_done_i=1, then go to DRAIN.
  - A timeout counter increments each WAIT cycle. If it reaches TIMEOUT: set err_o and go to IDLE.
  - A timeout abort does not restore the popped TX words.
- DRAIN: assert acc_read_o for one cycle per result, len strobes total.
  - acc_dout_i is valid exactly 1 cycle after each strobe and is pushed into the RX buffer that cycle.
  - Issue a strobe only if RX count + in-flight reads < DEPTH; otherwise stall with acc_read_o=0. Strobes may issue back-to-back.
  - After the len-th strobe, go to FLUSH.
- FLUSH: capture the final word, then return to IDLE. busy_o drops in the cycle after that capture.
- Latency for a job with len=N, done returned immediately, RX space available:
  - go accepted at cycle 0;
  - acc_start_o at cycle 1;
  - last load word at cycle N;
  - first read at N+2;
  - last capture at 2N+2;
  - busy_o=0 at 2N+3.
- A write to the job length register is allowed only on go acceptance. len_i is ignored at all other times.

Optional Feature:
- Macro: ACC_SEQ_PERF_EN.
- Defined: a 32-bit counter clears on go acceptance and increments every cycle while busy_o=1, saturating at 0xFFFFFFFF. perf_cycles_o holds the last job's final value until the next accepted go.
- Undefined: no counter logic is built and perf_cycles_o is tied to 0.

Test Plan:
- Push 4 words 0x00000001, 0x00000002, 0x00000003, 0x80000000; go with len=4; accelerator model bit-reverses and raises done 5 cycles after the last word -> RX pops 0x80000000, 0x40000000, 0xC0000000, 0x00000001 in order; err_o=0; acc_start_o is high exactly once.
- Push 2 words, then go with len=3 -> err_o=1, busy_o stays 0, no acc_start_o. Then push 1 more word and go with len=3 -> accepted and err_o cleared.
- Run a DEPTH=16 job with rd_ready_i=0 throughout -> all 16 results fill the RX buffer; rd_ready_i held low while the RX buffer is full -> no capture is lost and the 16 words pop in order.
- Keep acc_done_i low -> err_o=1 after exactly TIMEOUT WAIT cycles, busy_o=0, no acc_read_o pulses.
- Assert rst_n low midway through a len=8 LOAD -> all outputs 0 and buffers empty while rst_n is low; after release, a new 2-word job completes correctly.
- With ACC_SEQ_PERF_EN defined, a len=1 job with done returned immediately -> perf_cycles_o = 5; without the macro, perf_cycles_o = 0.
